// File: rtl/fifo_frame_writer.sv
// Write-side front end for the clock-crossing frame FIFOs: packs byte beats into
// tagged {last, err, data} words and applies the stall-or-drop policy at frame start.
module fifo_frame_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  wclk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  in_error,
  input  logic                  drop_when_full,
  input  logic                  fifo_full,
  output logic                  fifo_write_enable,
  output logic [DATA_WIDTH+1:0] fifo_write_data,
  output logic [CNT_WIDTH-1:0]  frames_written,
  output logic [CNT_WIDTH-1:0]  frames_dropped,
  output logic [1:0]            debug_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state;
  logic                  out_valid;
  logic [DATA_WIDTH+1:0] out_word;
  logic                  word_xfer;
  logic                  space;
  logic                  drop_start;
  logic                  accept;
  logic                  load;

  // Handshakes: a beat moves on in_valid && in_ready; a FIFO word moves on
  // fifo_write_enable && !fifo_full, and the enable is simply held while full.
  assign word_xfer  = out_valid && !fifo_full;
  assign space      = !out_valid || !fifo_full;
  assign drop_start = (state == IDLE) && in_valid && drop_when_full && fifo_full;

  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
      case (state)
        IDLE:    in_ready = drop_start || space;
        PASS:    in_ready = space;
        DROP:    in_ready = 1'b1;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;
  assign load   = accept && !drop_start && (state != DROP);

  assign fifo_write_enable = out_valid;
  assign fifo_write_data   = out_word;
  assign debug_state       = state;

  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      out_valid      <= 1'b0;
      out_word       <= '0;
      frames_written <= '0;
      frames_dropped <= '0;
    end else begin
      // A newly loaded beat overwrites a word that is leaving this same edge.
      if (load) begin
        out_valid <= 1'b1;
        out_word  <= {in_last, in_error & in_last, in_data};
      end else if (word_xfer) begin
        out_valid <= 1'b0;
      end

      if (word_xfer && out_word[DATA_WIDTH+1] && (frames_written != CNT_MAX))
        frames_written <= frames_written + 1'b1;

      if (accept && in_last && (drop_start || state == DROP) && (frames_dropped != CNT_MAX))
        frames_dropped <= frames_dropped + 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            if (drop_start)    state <= in_last ? IDLE : DROP;
            else if (!in_last) state <= PASS;
          end
        end
        PASS:    if (accept && in_last) state <= IDLE;
        DROP:    if (accept && in_last) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_frame_writer.sv
// Bench for fifo_frame_writer: frame-level reference model feeding an expected-word
// queue, with a negedge monitor comparing FIFO writes, handshake and counters.
module tb_fifo_frame_writer;

  localparam int DW = 8;
  localparam int CW = 2;

  logic          wclk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_error;
  logic          drop_when_full;
  logic          fifo_full;
  logic          fifo_write_enable;
  logic [DW+1:0] fifo_write_data;
  logic [CW-1:0] frames_written;
  logic [CW-1:0] frames_dropped;
  logic [1:0]    debug_state;

  fifo_frame_writer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .wclk              (wclk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_last           (in_last),
    .in_error          (in_error),
    .drop_when_full    (drop_when_full),
    .fifo_full         (fifo_full),
    .fifo_write_enable (fifo_write_enable),
    .fifo_write_data   (fifo_write_data),
    .frames_written    (frames_written),
    .frames_dropped    (frames_dropped),
    .debug_state       (debug_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    wclk = 1'b0;
    forever #5 wclk = ~wclk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model state ----------------
  int assertions = 0;
  int failures   = 0;
  logic [DW+1:0] exp_q[$];
  logic [CW-1:0] m_written = '0;
  logic [CW-1:0] m_dropped = '0;
  bit in_frame = 0;
  bit dropping = 0;
  int beats_acc = 0;
  bit full_rand = 0;
  bit full_force = 0;
  logic [DW-1:0] fd[16];
  bit fe[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_written = '0;
    m_dropped = '0;
    in_frame  = 0;
    dropping  = 0;
  endtask

  // fifo_full is driven only here, from the scenario controls.
  initial begin
    fifo_full = 1'b0;
    forever begin
      @(posedge wclk);
      #2;
      fifo_full = full_rand ? ($urandom_range(0, 2) == 0) : full_force;
    end
  end

  // ---------------- monitor ----------------
  logic [DW+1:0] popped;
  bit start_drop;
  bit exp_rdy;

  always @(negedge wclk) begin
    if (reset) begin
      check("ready_in_reset", in_ready, 0);
      check("wen_in_reset", fifo_write_enable, 0);
    end else begin
      check("frames_written", frames_written, m_written);
      check("frames_dropped", frames_dropped, m_dropped);
      start_drop = !in_frame && in_valid && drop_when_full && fifo_full;
      exp_rdy = (in_frame && dropping) || start_drop || (exp_q.size() == 0) || !fifo_full;
      check("in_ready", in_ready, exp_rdy);
      check("write_enable_pending", fifo_write_enable, exp_q.size() != 0);
      if (fifo_write_enable && !fifo_full && exp_q.size() != 0) begin
        popped = exp_q.pop_front();
        check("fifo_word", fifo_write_data, popped);
        if (popped[DW+1]) m_written = sat_inc(m_written);
      end
      if (in_valid && in_ready) begin
        beats_acc++;
        if (!in_frame) dropping = start_drop;
        if (!dropping) exp_q.push_back({in_last, in_error & in_last, in_data});
        else if (in_last) m_dropped = sat_inc(m_dropped);
        in_frame = !in_last;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [DW-1:0] d, input bit last, input bit err);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_error = err;
    acc = 0;
    n = 0;
    while (!acc && n < 300) begin
      @(negedge wclk);
      acc = in_ready;
      @(posedge wclk);
      #1;
      n++;
    end
    if (!acc) check("beat_accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_error = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge wclk);
      #1;
    end
  endtask

  task automatic send_frame(input int len, input int stop);
    for (int i = 0; i < len && i < stop; i++)
      drive_beat(fd[i], (i == len - 1) && (stop >= len), fe[i]);
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) begin
      fd[i] = DW'($urandom_range(0, 255));
      fe[i] = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic drain();
    full_rand  = 0;
    full_force = 0;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(posedge wclk);
    repeat (3) @(posedge wclk);
    #1;
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge wclk);
    #3;
    reset = 1'b1;
    model_clear();
    @(posedge wclk);
    #3;
    reset = 1'b0;
    @(posedge wclk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int b0;

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    in_error = 1'b0;
    drop_when_full = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
    check("reset_wen", fifo_write_enable, 0);
    check("reset_wdata", fifo_write_data, 0);
    check("reset_written", frames_written, 0);
    check("reset_dropped", frames_dropped, 0);
    check("reset_ready", in_ready, 0);
    check("reset_state_idle", debug_state, 0);
    #2;
    reset = 1'b0;
    @(posedge wclk);
    #1;

    // Single frame, FIFO never full.
    fd[0] = 8'h11; fd[1] = 8'h22; fd[2] = 8'h33; fd[3] = 8'h44;
    for (int i = 0; i < 4; i++) fe[i] = 0;
    send_frame(4, 4);
    drain();
    check("single_frames_written", frames_written, 1);

    // Stall policy: full at frame start for 5 cycles.
    do_reset();
    drop_when_full = 1'b0;
    full_force = 1;
    fill_random(3);
    b0 = beats_acc;
    fork
      send_frame(3, 3);
      begin
        repeat (5) @(posedge wclk);
        check("stall_beats_during_full", (beats_acc - b0) <= 1, 1);
        #1;
        full_force = 0;
      end
    join
    drain();
    check("stall_frames_dropped", frames_dropped, 0);
    check("stall_frames_written", frames_written, 1);

    // Drop policy: full at the first beat drops the whole 6-beat frame.
    do_reset();
    drop_when_full = 1'b1;
    full_force = 1;
    @(posedge wclk);
    #1;
    fill_random(6);
    send_frame(6, 6);
    full_force = 0;
    fill_random(3);
    send_frame(3, 3);
    drain();
    check("drop_frames_dropped", frames_dropped, 1);
    check("drop_next_frame_written", frames_written, 1);

    // Mid-frame full with drop policy never truncates.
    do_reset();
    drop_when_full = 1'b1;
    fill_random(5);
    b0 = beats_acc;
    fork
      send_frame(5, 5);
      begin
        for (int c = 0; c < 100 && beats_acc < b0 + 2; c++) @(posedge wclk);
        #1;
        full_force = 1;
        repeat (3) @(posedge wclk);
        #1;
        full_force = 0;
      end
    join
    drain();
    check("midfull_frames_written", frames_written, 1);
    check("midfull_frames_dropped", frames_dropped, 0);

    // Error tag: error on a non-last beat is ignored, on the last beat it tags.
    do_reset();
    drop_when_full = 1'b0;
    fd[0] = 8'h01; fd[1] = 8'h02; fd[2] = 8'hAB;
    fe[0] = 1; fe[1] = 0; fe[2] = 1;
    send_frame(3, 3);
    drain();
    check("err_frames_written", frames_written, 1);

    // Counter saturation on drops.
    do_reset();
    drop_when_full = 1'b1;
    full_force = 1;
    @(posedge wclk);
    #1;
    for (int f = 0; f < 5; f++) begin
      fill_random(2);
      send_frame(2, 2);
    end
    drain();
    check("sat_frames_dropped", frames_dropped, 3);

    // Randomized frames, policy and FIFO backpressure.
    do_reset();
    full_rand = 1;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 6);
      drop_when_full = $urandom_range(0, 1);
      fill_random(len);
      send_frame(len, len);
    end
    drain();

    // Async reset mid-frame with a word held by a full FIFO.
    do_reset();
    drop_when_full = 1'b0;
    fill_random(6);
    send_frame(6, 3);
    full_force = 1;
    @(posedge wclk);
    #3;
    reset = 1'b1;
    #1;
    check("async_wen", fifo_write_enable, 0);
    check("async_wdata", fifo_write_data, 0);
    check("async_written", frames_written, 0);
    check("async_dropped", frames_dropped, 0);
    check("async_ready", in_ready, 0);
    model_clear();
    full_force = 0;
    repeat (2) @(posedge wclk);
    #3;
    reset = 1'b0;
    @(posedge wclk);
    #1;
    for (int i = 0; i < 3; i++) begin
      fd[i] = fd[i + 3];
      fe[i] = fe[i + 3];
    end
    send_frame(3, 3);
    drain();
    check("after_reset_frames_written", frames_written, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
